fp32_norm_pack: RTL and testbench
=================================

Name: fp32_norm_pack

Overview:
- Back end of the FP32 multiplier datapath: drains the sign/exponent/product registers and produces an IEEE-754 single-precision word.
- Normalizes a 48-bit significand product iteratively, one bit per cycle.
- Rounds round-to-nearest-even, handles overflow, underflow and zero, and packs the 32-bit result.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- EXP_W, 10: width of signed biased input exponent (two's complement).
- MAN_W, 48: width of significand product; value = man_in * 2^-46.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept (high only in IDLE).
- sign_in  input  1  result sign.
- exp_in  input  EXP_W  signed biased exponent (sum of operand exponents minus 127).
- man_in  input  MAN_W  significand product, hidden bits included.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  32  packed FP32 result.

Behaviour:
- Reset values: state IDLE, out_valid 0, out_data 0x00000000, in_ready 1; working registers cleared.
- Reset mid-operation aborts without producing output and takes priority over every other event.
- Accept on in_valid && in_ready at a rising edge. Capture sign, exp, man; clear the sticky register; go to NORM.
- NORM (one action per cycle, in this priority):
  1. man == 0: result = {sign, 31'b0}; go to DONE.
  2. man[47] == 1: man >>= 1, sticky |= dropped bit, exp += 1; stay in NORM.
  3. man[46] == 0 and exp > 1: man <<= 1, exp -= 1; stay in NORM.
  4. Otherwise: go to ROUND.
- ROUND (single cycle), then DONE:
  - sig = man[46:23], guard = man[22], sticky_all = |man[21:0] | sticky.
  - inc = guard & (sticky_all | sig[0]). sig_r = sig + inc (25-bit).
  - If sig_r[24] is set: exp += 1 and frac = 0; else frac = sig_r[22:0].
  - Underflow (exp <= 0, or man[46] == 0): result = {sign, 31'b0} (flush to zero, no subnormal output).
  - Overflow (exp >= 255 after the rounding adjust): result = {sign, 8'hFF, 23'b0}.
  - Otherwise: result = {sign, exp[7:0], frac}.
- DONE:
  - out_valid = 1 and out_data stable until out_ready is sampled high; then out_valid = 0 and go to IDLE.
  - in_ready stays low in DONE; no new accept in the same cycle as the out handshake.
- Latency from the accept edge to out_valid high:
  - man[46] set: 2 cycles.
  - man[47] set: 3 cycles.
  - Each left shift adds 1 cycle.
  - Zero product: 1 cycle.
- out_data holds its last value after leaving DONE, until the next result.
- Exponent arithmetic is done at EXP_W bits, signed. Products of normal operands never need more than 1 right shift. Denormal operand products may need up to 46 left shifts; shifting stops when exp reaches 1.

Optional Feature:
- Macro FP_PACK_FLAGS_EN.
- Defined: adds output ports flag_ovf, flag_unf, flag_inx (1 bit each). They are registered alongside out_data and valid with out_valid. Reset to 0.
  - flag_inx = guard | sticky_all, or any overflow/underflow result.
  - flag_ovf marks an overflow result; flag_unf marks a non-zero input flushed to zero.
  - Zero product: all flags 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- 1.0*1.0: sign 0, exp 127, man 0x400000000000 -> out_data 0x3F800000, out_valid 2 cycles after accept, flags 0.
- 1.5*1.5: exp 127, man 0x900000000000 -> one right shift, 0x40100000, latency 3.
- Rounding:
  - man 0x400000400000 (tie, sig even), exp 127 -> 0x3F800000, inx 1.
  - man 0x400000C00000 (tie, sig odd), exp 127 -> 0x3F800002.
- Special results:
  - exp 254, man 0x800000000000 -> 0x7F800000, ovf 1.
  - exp -5, man 0x400000000000, sign 1 -> 0x80000000, unf 1.
  - man 0, sign 1 -> 0x80000000, latency 1.
- Handshake:
  - Hold out_ready low 5 cycles: out_valid and out_data held, in_ready 0, in_valid ignored.
  - Assert reset during NORM of a man 0x000000400000 operand -> out_valid stays 0, in_ready 1 the cycle after reset deasserts, next operation correct.

Source files
------------

// File: rtl/fp32_norm_pack.sv
// FP32 multiplier back end: bit-serial normalization, round-to-nearest-even, pack.
// Define FP_PACK_FLAGS_EN to add the flag_ovf / flag_unf / flag_inx outputs.
module fp32_norm_pack #(
    parameter int EXP_W = 10,
    parameter int MAN_W = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic signed [EXP_W-1:0] exp_in,
    input  logic [MAN_W-1:0]        man_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data
`ifdef FP_PACK_FLAGS_EN
    ,
    output logic                    flag_ovf,
    output logic                    flag_unf,
    output logic                    flag_inx
`endif
);

    localparam int TOP = MAN_W - 1;   // overflow bit of the product (value >= 2)
    localparam int HID = MAN_W - 2;   // hidden-one position of a normalized value
    localparam int GRD = MAN_W - 26;  // first bit below the 24-bit significand

    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [MAN_W-1:0]        man_q, man_d;
    logic                    sticky_q, sticky_d;
    logic                    out_valid_q, out_valid_d;
    logic [31:0]             out_data_q, out_data_d;

    // Rounding datapath, only consumed in ROUND.
    logic [23:0]             rnd_sig;
    logic                    rnd_guard;
    logic                    rnd_sticky;
    logic                    rnd_inc;
    logic [24:0]             rnd_sig_r;
    logic signed [EXP_W-1:0] rnd_exp;
    logic [22:0]             rnd_frac;
    logic                    rnd_unf;
    logic                    rnd_ovf;
    logic                    rnd_inx;
    logic [31:0]             rnd_word;

    assign rnd_sig    = man_q[HID -: 24];
    assign rnd_guard  = man_q[GRD];
    assign rnd_sticky = (|man_q[GRD-1:0]) | sticky_q;
    assign rnd_inc    = rnd_guard & (rnd_sticky | rnd_sig[0]);
    assign rnd_sig_r  = {1'b0, rnd_sig} + {24'b0, rnd_inc};
    assign rnd_exp    = rnd_sig_r[24] ? exp_q + EXP_ONE : exp_q;
    // On a carry-out the significand is exactly 2.0, so bits [23:1] are all zero.
    assign rnd_frac   = rnd_sig_r[24] ? rnd_sig_r[23:1] : rnd_sig_r[22:0];
    assign rnd_unf    = (exp_q <= EXP_ZERO) || !man_q[HID];
    assign rnd_ovf    = !rnd_unf && (rnd_exp >= EXP_MAX);
    assign rnd_inx    = rnd_guard | rnd_sticky | rnd_unf | rnd_ovf;

    always_comb begin
        rnd_word = {sign_q, rnd_exp[7:0], rnd_frac};
        if (rnd_unf) begin
            rnd_word = {sign_q, 31'b0};
        end else if (rnd_ovf) begin
            rnd_word = {sign_q, 8'hFF, 23'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        man_d       = man_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = sign_in;
                    exp_d    = exp_in;
                    man_d    = man_in;
                    sticky_d = 1'b0;
                    state_d  = NORM;
                end
            end
            NORM: begin
                if (man_q == '0) begin
                    out_data_d  = {sign_q, 31'b0};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (man_q[TOP]) begin
                    man_d    = man_q >> 1;
                    sticky_d = sticky_q | man_q[0];
                    exp_d    = exp_q + EXP_ONE;
                end else if (!man_q[HID] && (exp_q > EXP_ONE)) begin
                    // Left shifts stop at exp 1; anything still short underflows.
                    man_d = man_q << 1;
                    exp_d = exp_q - EXP_ONE;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                out_data_d  = rnd_word;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            man_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            man_q       <= man_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef FP_PACK_FLAGS_EN
    logic [2:0] flags_q, flags_d;  // {ovf, unf, inx}

    always_comb begin
        flags_d = flags_q;
        if (state_q == NORM && man_q == '0) begin
            flags_d = 3'b000;
        end else if (state_q == ROUND) begin
            flags_d = {rnd_ovf, rnd_unf, rnd_inx};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flag_ovf = flags_q[2];
    assign flag_unf = flags_q[1];
    assign flag_inx = flags_q[0];
`endif

endmodule

// File: tb/tb_fp32_norm_pack.sv
// Scoreboard bench for fp32_norm_pack: directed vectors, monitor checks data, latency, flags.
module tb_fp32_norm_pack;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               sign_in = 1'b0;
    logic signed [9:0]  exp_in = '0;
    logic [47:0]        man_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_data;
`ifdef FP_PACK_FLAGS_EN
    logic               flag_ovf, flag_unf, flag_inx;
`endif

    fp32_norm_pack #(.EXP_W(10), .MAN_W(48)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .man_in    (man_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FP_PACK_FLAGS_EN
        ,
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inx  (flag_inx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          lat;
        logic [2:0]  fl;   // {ovf, unf, inx}
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   edges = 0;
    bit   seen = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=expired required=event", nm);
    endtask

    // Monitor: first cycle of each result checks data, latency and flags; later
    // cycles check that the result is held and the input side stays closed.
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none", out_data);
                end else begin
                    cur = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(cur.data));
                    chk("latency", 64'(edges - cur.acc), 64'(cur.lat));
`ifdef FP_PACK_FLAGS_EN
                    chk("flags", 64'({flag_ovf, flag_unf, flag_inx}), 64'(cur.fl));
`endif
                end
            end else begin
                chk("out_data_held", 64'(out_data), 64'(cur.data));
            end
            chk("in_ready_done", 64'(in_ready), 64'(0));
            if (out_ready) seen = 1'b0;
        end
    end

    task automatic issue(input logic s, input logic [9:0] e, input logic [47:0] m,
                         input logic [31:0] d, input int lat, input logic [2:0] fl,
                         input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout("in_ready");
        sign_in  = s;
        exp_in   = e;
        man_in   = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) sb.push_back('{d, lat, fl, edges});
    endtask

    task automatic drain(input logic [31:0] last);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0 || out_valid) timeout("drain");
        else chk("out_data_idle_hold", 64'(out_data), 64'(last));
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_data", 64'(out_data), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
`ifdef FP_PACK_FLAGS_EN
        chk("reset_flags", 64'({flag_ovf, flag_unf, flag_inx}), 64'(0));
`endif
        reset = 1'b0;

        //     sign  exp       man               expected      lat flags   push
        issue(1'b0, 10'sd127, 48'h400000000000, 32'h3F800000, 2, 3'b000, 1); drain(32'h3F800000);
        issue(1'b0, 10'sd127, 48'h900000000000, 32'h40100000, 3, 3'b000, 1); drain(32'h40100000);
        issue(1'b0, 10'sd127, 48'h400000400000, 32'h3F800000, 2, 3'b001, 1); drain(32'h3F800000);
        issue(1'b0, 10'sd127, 48'h400000C00000, 32'h3F800002, 2, 3'b001, 1); drain(32'h3F800002);
        issue(1'b0, 10'sd254, 48'h800000000000, 32'h7F800000, 3, 3'b101, 1); drain(32'h7F800000);
        issue(1'b1, -10'sd5,  48'h400000000000, 32'h80000000, 2, 3'b011, 1); drain(32'h80000000);
        issue(1'b1, 10'sd127, 48'h000000000000, 32'h80000000, 1, 3'b000, 1); drain(32'h80000000);
        issue(1'b0, 10'sd127, 48'h200000000000, 32'h3F000000, 3, 3'b000, 1); drain(32'h3F000000);
        issue(1'b0, 10'sd3,   48'h010000000000, 32'h00000000, 4, 3'b011, 1); drain(32'h00000000);
        issue(1'b0, 10'sd127, 48'h7FFFFFC00000, 32'h40000000, 2, 3'b001, 1); drain(32'h40000000);
        issue(1'b0, 10'sd254, 48'h7FFFFFC00000, 32'h7F800000, 2, 3'b101, 1); drain(32'h7F800000);
        issue(1'b0, 10'sd127, 48'hC00000000001, 32'h40400000, 3, 3'b001, 1); drain(32'h40400000);

        // Back-pressure: result held for 5 cycles while a new operand is offered.
        out_ready = 1'b0;
        issue(1'b1, 10'sd127, 48'h400000000000, 32'hBF800000, 2, 3'b000, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout("hold_out_valid");
        sign_in  = 1'b0;
        exp_in   = 10'sd127;
        man_in   = 48'h900000000000;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(32'hBF800000);

        // Reset during a long left-shift sequence aborts with no output.
        issue(1'b0, 10'sd127, 48'h000000400000, 32'h0, 26, 3'b000, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        repeat (30) @(negedge clk);
        chk("abort_no_output", 64'(out_valid), 64'(0));
        issue(1'b0, 10'sd127, 48'h000000400000, 32'h33800000, 26, 3'b000, 1); drain(32'h33800000);

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
